uart_rs232_rx_frontend: RTL and testbench

//  UART receive counterpart of the RS-232 transmit path: samples asynchronous

---
 rtl/uart_rs232_rx_frontend.sv | 287 ++++++++++++++++++++++++++++
 tb/tb_uart_rs232_rx_frontend.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rs232_rx_frontend.sv
// ---------------------------------------------------------------------------
// uart_rs232_rx_frontend
//   UART receiver for the RS-232 path. It synchronises the asynchronous Rx
//   line and runs a 16x oversample tick divider. Each bit is sampled three
//   times and resolved by majority vote. A framing FSM checks the start bit,
//   data bits, optional parity bit and stop bit. A one-entry holding register
//   with a valid/ready handshake presents the received byte.
//
//   Optional feature macro: UART_RX_PARITY_EN
//     defined   -> one even-parity bit is expected between the data and stop
//                  bits, and ParityErr is driven.
//     undefined -> the frame is start + NBITS + stop, and ParityErr is always 0.
//
// Ports
//   Clk        in   1      system clock, posedge
//   Rst_n      in   1      synchronous active-low reset
//   Rx         in   1      asynchronous serial line, idle high
//   BaudDiv    in   16     tick period minus 1 (baud = Fclk/((BaudDiv+1)*16))
//   RxReady    in   1      consumer takes RxData when RxValid && RxReady
//   RxData     out  NBITS  holding register
//   RxValid    out  1      holding register full
//   RxBusy     out  1      FSM not idle
//   FrameErr   out  1      1-clk pulse, stop bit sampled low
//   Overrun    out  1      1-clk pulse, frame completed while holding reg full
//   ParityErr  out  1      1-clk pulse, parity mismatch (with the byte load)
// ---------------------------------------------------------------------------
module uart_rs232_rx_frontend #(
  parameter int NBITS       = 8,
  parameter int OVERSAMPLE  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             Rx,
  input  logic [15:0]      BaudDiv,
  input  logic             RxReady,
  output logic [NBITS-1:0] RxData,
  output logic             RxValid,
  output logic             RxBusy,
  output logic             FrameErr,
  output logic             Overrun,
  output logic             ParityErr
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] PARITY = 3'd3;
`endif
  localparam logic [2:0] STOP   = 3'd4;
  localparam logic [2:0] BRK    = 3'd5;

  localparam logic [3:0] S_LAST   = 4'(OVERSAMPLE - 1);
  localparam logic [3:0] S_SAMP0  = 4'd7;
  localparam logic [3:0] S_SAMP1  = 4'd8;
  localparam logic [3:0] S_DECIDE = 4'd9;
  localparam logic [2:0] IDX_LAST = 3'(NBITS - 1);

  function automatic logic maj3(input logic a, input logic b, input logic c);
    maj3 = (a & b) | (a & c) | (b & c);
  endfunction

  function automatic logic evenParity(input logic [NBITS-1:0] d);
    evenParity = ^d;
  endfunction

  logic [SYNC_STAGES-1:0] rxSync_r;
  logic                   rxs_s;
  logic [15:0]            divCnt_r;
  logic [15:0]            divLatch_r;
  logic                   tick_s;

  logic [2:0]       state_r,   stateNext_s;
  logic [3:0]       sCnt_r,    sCntNext_s;
  logic [2:0]       bitIdx_r,  bitIdxNext_s;
  logic [NBITS-1:0] shift_r,   shiftNext_s;
  logic             samp7_r,   samp7Next_s;
  logic             samp8_r,   samp8Next_s;
  logic             maj_s;
  logic             deliver_s;
  logic             frameErr_s;
`ifdef UART_RX_PARITY_EN
  logic             parErr_r,  parErrNext_s;
`endif

  assign rxs_s  = rxSync_r[SYNC_STAGES-1];
  assign tick_s = (divCnt_r == divLatch_r);
  // third sample is the live synchronised line at the deciding tick
  assign maj_s  = maj3(samp7_r, samp8_r, rxs_s);

  // Rx synchroniser, idles high so reset never looks like a start bit
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      rxSync_r <= {SYNC_STAGES{1'b1}};
    end else begin
      rxSync_r <= {rxSync_r[SYNC_STAGES-2:0], Rx};
    end
  end

  // Oversample tick divider; BaudDiv is latched at wrap so a change mid-period
  // cannot make the counter run past its terminal value
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      divCnt_r   <= 16'd0;
      divLatch_r <= BaudDiv;
    end else if (tick_s) begin
      divCnt_r   <= 16'd0;
      divLatch_r <= BaudDiv;
    end else begin
      divCnt_r   <= divCnt_r + 16'd1;
    end
  end

  // Framing FSM next-state logic; every decision is qualified by tick_s
  always_comb begin
    stateNext_s  = state_r;
    sCntNext_s   = sCnt_r;
    bitIdxNext_s = bitIdx_r;
    shiftNext_s  = shift_r;
    samp7Next_s  = samp7_r;
    samp8Next_s  = samp8_r;
    deliver_s    = 1'b0;
    frameErr_s   = 1'b0;
`ifdef UART_RX_PARITY_EN
    parErrNext_s = parErr_r;
`endif
    if (tick_s) begin
      if (sCnt_r == S_SAMP0) begin
        samp7Next_s = rxs_s;
      end else begin
        samp7Next_s = samp7_r;
      end
      if (sCnt_r == S_SAMP1) begin
        samp8Next_s = rxs_s;
      end else begin
        samp8Next_s = samp8_r;
      end
      case (state_r)
        IDLE: begin
          if (!rxs_s) begin
            stateNext_s  = START;
            sCntNext_s   = 4'd0;
`ifdef UART_RX_PARITY_EN
            parErrNext_s = 1'b0;
`endif
          end else begin
            stateNext_s = IDLE;
          end
        end
        START: begin
          sCntNext_s = sCnt_r + 4'd1;
          if ((sCnt_r == S_DECIDE) && maj_s) begin
            stateNext_s = IDLE;          // glitch, silently dropped
          end else if (sCnt_r == S_LAST) begin
            stateNext_s  = DATA;
            bitIdxNext_s = 3'd0;
          end else begin
            stateNext_s = START;
          end
        end
        DATA: begin
          sCntNext_s = sCnt_r + 4'd1;
          if (sCnt_r == S_DECIDE) begin
            shiftNext_s = {maj_s, shift_r[NBITS-1:1]};   // LSB first
          end else begin
            shiftNext_s = shift_r;
          end
          if (sCnt_r == S_LAST) begin
            if (bitIdx_r == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
              stateNext_s = PARITY;
`else
              stateNext_s = STOP;
`endif
            end else begin
              bitIdxNext_s = bitIdx_r + 3'd1;
            end
          end else begin
            stateNext_s = DATA;
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          sCntNext_s = sCnt_r + 4'd1;
          if (sCnt_r == S_DECIDE) begin
            parErrNext_s = (maj_s != evenParity(shift_r));
          end else begin
            parErrNext_s = parErr_r;
          end
          if (sCnt_r == S_LAST) begin
            stateNext_s = STOP;
          end else begin
            stateNext_s = PARITY;
          end
        end
`endif
        STOP: begin
          sCntNext_s = sCnt_r + 4'd1;
          // decide half a bit early so a back-to-back start edge is not missed
          if (sCnt_r == S_DECIDE) begin
            if (maj_s) begin
              stateNext_s = IDLE;
              deliver_s   = 1'b1;
            end else begin
              stateNext_s = BRK;
              frameErr_s  = 1'b1;
            end
          end else begin
            stateNext_s = STOP;
          end
        end
        BRK: begin
          // hold off until the line returns high so a stuck-low line
          // does not produce a stream of zero bytes
          if (rxs_s) begin
            stateNext_s = IDLE;
          end else begin
            stateNext_s = BRK;
          end
        end
        default: begin
          stateNext_s = IDLE;
        end
      endcase
    end else begin
      stateNext_s = state_r;
    end
  end

  // Framing FSM state registers
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_r  <= IDLE;
      sCnt_r   <= 4'd0;
      bitIdx_r <= 3'd0;
      shift_r  <= {NBITS{1'b0}};
      samp7_r  <= 1'b1;
      samp8_r  <= 1'b1;
`ifdef UART_RX_PARITY_EN
      parErr_r <= 1'b0;
`endif
    end else begin
      state_r  <= stateNext_s;
      sCnt_r   <= sCntNext_s;
      bitIdx_r <= bitIdxNext_s;
      shift_r  <= shiftNext_s;
      samp7_r  <= samp7Next_s;
      samp8_r  <= samp8Next_s;
`ifdef UART_RX_PARITY_EN
      parErr_r <= parErrNext_s;
`endif
    end
  end

  // Holding register, handshake and registered status pulses
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      RxData    <= {NBITS{1'b0}};
      RxValid   <= 1'b0;
      RxBusy    <= 1'b0;
      FrameErr  <= 1'b0;
      Overrun   <= 1'b0;
      ParityErr <= 1'b0;
    end else begin
      RxBusy    <= (stateNext_s != IDLE);
      FrameErr  <= frameErr_s;
      Overrun   <= 1'b0;
      ParityErr <= 1'b0;
      if (deliver_s) begin
        // a same-clock handshake frees the register for the new byte
        if (!RxValid || RxReady) begin
          RxData    <= shift_r;
          RxValid   <= 1'b1;
`ifdef UART_RX_PARITY_EN
          ParityErr <= parErr_r;
`endif
        end else begin
          Overrun   <= 1'b1;
        end
      end else if (RxValid && RxReady) begin
        RxValid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rs232_rx_frontend.sv
// ---------------------------------------------------------------------------
// tb_uart_rs232_rx_frontend
//   Directed bench for uart_rs232_rx_frontend at BaudDiv=0 (16 clk per bit).
//   Serial frames are driven on negedges. A monitor counts the status pulses
//   and handshakes, and expected values are hand-computed constants.
//   Builds with or without UART_RX_PARITY_EN.
// ---------------------------------------------------------------------------
module tb_uart_rs232_rx_frontend;

  localparam int SYNC = 2;
`ifdef UART_RX_PARITY_EN
  localparam int PBITS = 1;
`else
  localparam int PBITS = 0;
`endif
  // 2 sync flops + 1 detect clk + start/data/parity bits + stop up to s=9 + load
  localparam int LAT_EXP = SYNC + 1 + 16 * (1 + 8 + PBITS) + 10;

  logic        Clk = 1'b0;
  logic        Rst_n = 1'b0;
  logic        Rx = 1'b1;
  logic [15:0] BaudDiv = 16'd0;
  logic        RxReady = 1'b0;
  logic [7:0]  RxData;
  logic        RxValid, RxBusy, FrameErr, Overrun, ParityErr;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int startCyc = 0;
  int riseCyc = 0;
  int parCyc = 0;
  int frameErrCnt = 0;
  int overrunCnt = 0;
  int parityErrCnt = 0;
  int fe0, ov0, pe0;
  logic validPrev = 1'b0;
  logic [7:0] hsData[$];

  uart_rs232_rx_frontend #(.NBITS(8), .OVERSAMPLE(16), .SYNC_STAGES(SYNC)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Rx(Rx), .BaudDiv(BaudDiv), .RxReady(RxReady),
    .RxData(RxData), .RxValid(RxValid), .RxBusy(RxBusy), .FrameErr(FrameErr),
    .Overrun(Overrun), .ParityErr(ParityErr)
  );

  always #5 Clk = ~Clk;

  // cycle counter
  always @(posedge Clk) cyc <= cyc + 1;

  // event monitor, sampled just after the negedge when inputs have settled
  always @(negedge Clk) begin
    #1;
    validPrev <= RxValid;
    if (RxValid && !validPrev) riseCyc <= cyc;
    if (FrameErr) frameErrCnt <= frameErrCnt + 1;
    if (Overrun) overrunCnt <= overrunCnt + 1;
    if (ParityErr) begin
      parityErrCnt <= parityErrCnt + 1;
      parCyc <= cyc;
    end
    if (RxValid && RxReady) hsData.push_back(RxData);
  end

  task automatic checkEq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic sendBit(input logic b);
    Rx = b;
    repeat (16) @(negedge Clk);
  endtask

  task automatic sendFrame(input logic [7:0] data, input logic stopVal, input logic parFlip);
    startCyc = cyc;
    sendBit(1'b0);
    for (int i = 0; i < 8; i++) sendBit(data[i]);
`ifdef UART_RX_PARITY_EN
    sendBit((^data) ^ parFlip);
`else
    if (parFlip) $display("note: parity bit not part of this build");
`endif
    sendBit(stopVal);
  endtask

  task automatic consume();
    RxReady = 1'b1;
    @(negedge Clk);
    RxReady = 1'b0;
  endtask

  task automatic snap();
    fe0 = frameErrCnt;
    ov0 = overrunCnt;
    pe0 = parityErrCnt;
  endtask

  initial begin
    // reset state
    repeat (3) @(negedge Clk);
    checkEq("rst_data", 32'(RxData), 32'h0);
    checkEq("rst_valid", 32'(RxValid), 32'h0);
    checkEq("rst_busy", 32'(RxBusy), 32'h0);
    checkEq("rst_flags", {29'd0, FrameErr, Overrun, ParityErr}, 32'h0);
    Rst_n = 1'b1;
    repeat (5) @(negedge Clk);

    // clean 0xA5 frame with latency check
    snap();
    sendFrame(8'hA5, 1'b1, 1'b0);
    repeat (2) @(negedge Clk);
    checkEq("a5_valid", 32'(RxValid), 32'h1);
    checkEq("a5_data", 32'(RxData), 32'hA5);
    checkEq("a5_latency", 32'(riseCyc - startCyc), 32'(LAT_EXP));
    checkEq("a5_flags", 32'((frameErrCnt - fe0) + (overrunCnt - ov0) + (parityErrCnt - pe0)), 32'h0);
    consume();
    checkEq("a5_valid_clr", 32'(RxValid), 32'h0);

    // 5-clk low glitch is rejected in START
    Rx = 1'b0;
    repeat (4) @(negedge Clk);
    checkEq("glitch_busy", 32'(RxBusy), 32'h1);
    @(negedge Clk);
    Rx = 1'b1;
    repeat (30) @(negedge Clk);
    checkEq("glitch_idle", 32'(RxBusy), 32'h0);
    checkEq("glitch_valid", 32'(RxValid), 32'h0);

    // framing error, BREAK until line high, then clean 0x55
    snap();
    sendFrame(8'h3C, 1'b0, 1'b0);
    repeat (48) @(negedge Clk);
    checkEq("fe_pulse", 32'(frameErrCnt - fe0), 32'h1);
    checkEq("fe_valid", 32'(RxValid), 32'h0);
    checkEq("fe_break", 32'(RxBusy), 32'h1);
    Rx = 1'b1;
    repeat (6) @(negedge Clk);
    checkEq("fe_idle", 32'(RxBusy), 32'h0);
    sendFrame(8'h55, 1'b1, 1'b0);
    repeat (2) @(negedge Clk);
    checkEq("fe_next_valid", 32'(RxValid), 32'h1);
    checkEq("fe_next_data", 32'(RxData), 32'h55);
    checkEq("fe_next_noerr", 32'(frameErrCnt - fe0), 32'h1);
    consume();

    // back-to-back with consumer stalled -> overrun on second frame
    snap();
    sendFrame(8'h11, 1'b1, 1'b0);
    sendFrame(8'h22, 1'b1, 1'b0);
    repeat (4) @(negedge Clk);
    checkEq("ov_valid", 32'(RxValid), 32'h1);
    checkEq("ov_data", 32'(RxData), 32'h11);
    checkEq("ov_pulse", 32'(overrunCnt - ov0), 32'h1);
    consume();
    checkEq("ov_valid_clr", 32'(RxValid), 32'h0);

    // continuous stream with RxReady held high
    snap();
    hsData.delete();
    RxReady = 1'b1;
    sendFrame(8'h00, 1'b1, 1'b0);
    sendFrame(8'hFF, 1'b1, 1'b0);
    sendFrame(8'h81, 1'b1, 1'b0);
    repeat (4) @(negedge Clk);
    checkEq("cont_count", 32'(hsData.size()), 32'd3);
    if (hsData.size() >= 3) begin
      checkEq("cont_b0", 32'(hsData[0]), 32'h00);
      checkEq("cont_b1", 32'(hsData[1]), 32'hFF);
      checkEq("cont_b2", 32'(hsData[2]), 32'h81);
    end
    checkEq("cont_no_ov", 32'(overrunCnt - ov0), 32'h0);

    // reset in the middle of a fourth frame
    sendBit(1'b0);
    sendBit(1'b1);
    checkEq("mid_busy", 32'(RxBusy), 32'h1);
    Rst_n = 1'b0;
    @(negedge Clk);
    checkEq("mid_rst_data", 32'(RxData), 32'h0);
    checkEq("mid_rst_valid", 32'(RxValid), 32'h0);
    checkEq("mid_rst_busy", 32'(RxBusy), 32'h0);
    checkEq("mid_rst_flags", {29'd0, FrameErr, Overrun, ParityErr}, 32'h0);
    Rx = 1'b1;
    RxReady = 1'b0;
    @(negedge Clk);
    Rst_n = 1'b1;
    repeat (20) @(negedge Clk);
    snap();
    sendFrame(8'h5A, 1'b1, 1'b0);
    repeat (2) @(negedge Clk);
    checkEq("post_rst_valid", 32'(RxValid), 32'h1);
    checkEq("post_rst_data", 32'(RxData), 32'h5A);
    checkEq("post_rst_flags", 32'((frameErrCnt - fe0) + (overrunCnt - ov0)), 32'h0);
    consume();

`ifdef UART_RX_PARITY_EN
    // 0x07 has three ones, so the even-parity bit is 1; send 0 first
    snap();
    sendFrame(8'h07, 1'b1, 1'b1);
    repeat (2) @(negedge Clk);
    checkEq("par_bad_data", 32'(RxData), 32'h07);
    checkEq("par_bad_valid", 32'(RxValid), 32'h1);
    checkEq("par_bad_pulse", 32'(parityErrCnt - pe0), 32'h1);
    checkEq("par_bad_align", 32'(parCyc), 32'(riseCyc));
    consume();
    sendFrame(8'h07, 1'b1, 1'b0);
    repeat (2) @(negedge Clk);
    checkEq("par_ok_valid", 32'(RxValid), 32'h1);
    checkEq("par_ok_noerr", 32'(parityErrCnt - pe0), 32'h1);
    consume();
`else
    checkEq("par_tied_zero", 32'(parityErrCnt), 32'h0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
